// File: rtl/vga_bounce_gen.sv
// vga_bounce_gen: VGA timing generator drawing NOBJ bouncing filled circles on black
// Ports: clk pixel clock; rst async active-high reset; pause freezes motion at the frame update;
//   VGA_R/VGA_G/VGA_B colour (CW bits each); VGA_HS/VGA_VS syncs (active level HS_POL/VS_POL);
//   VGA_DE visible-pixel enable; frame_start one-clock pulse for pixel (0,0).
//   All outputs are registered one clock after the counter state they describe.
// Optional: define VGA_BORDER_EN for a white one-pixel frame around the visible area.
module vga_bounce_gen #(
  parameter int HWIDTH  = 640,
  parameter int HFPORCH = 16,
  parameter int HSYNC   = 96,
  parameter int HBPORCH = 48,
  parameter int VWIDTH  = 480,
  parameter int VFPORCH = 10,
  parameter int VSYNC   = 2,
  parameter int VBPORCH = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int CW      = 4,
  parameter int NOBJ    = 2,
  parameter int RADIUS  = 30,
  parameter int STEP    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pause,
  output logic [CW-1:0] VGA_R,
  output logic [CW-1:0] VGA_G,
  output logic [CW-1:0] VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic          frame_start
);
  localparam int HTOTAL = HWIDTH + HFPORCH + HSYNC + HBPORCH;
  localparam int VTOTAL = VWIDTH + VFPORCH + VSYNC + VBPORCH;
  localparam int HL = $clog2(HTOTAL);
  localparam int VL = $clog2(VTOTAL);
  localparam int PW = HL > VL ? HL : VL;
  localparam int SW = 2 * PW + 3;
  localparam logic HSA = 1'(HS_POL);
  localparam logic VSA = 1'(VS_POL);
  localparam logic [CW-1:0] FULL = '1;
  // {R,G,B} enables per object: 0 green, 1 red, 2 blue, 3 yellow
  localparam logic [11:0] PAL = {3'b110, 3'b001, 3'b100, 3'b010};
  logic [HL-1:0] hcnt_q, hcnt_d;
  logic [VL-1:0] vcnt_q, vcnt_d;
  logic h_end, v_end, upd, de_d, hs_d, vs_d, fs_d;
  logic [NOBJ-1:0] hit;
  logic [2:0] rgb_d;
  logic [CW-1:0] r_q, g_q, b_q;
  logic hs_q, vs_q, de_q, fs_q;
  // one axis step; returns {new_dir, new_pos}, dir 1 = decreasing
  function automatic logic [PW:0] mv(input logic [PW-1:0] p, input logic d, input logic [PW-1:0] hi);
    logic [PW:0] up;
    up = {1'b0, p} + (PW+1)'(STEP);
    if (!d) return up >= {1'b0, hi} ? {1'b1, hi} : {1'b0, up[PW-1:0]};
    return p <= PW'(RADIUS + STEP) ? {1'b0, PW'(RADIUS)} : {1'b1, p - PW'(STEP)};
  endfunction
  assign h_end  = hcnt_q == HL'(HTOTAL - 1);
  assign v_end  = vcnt_q == VL'(VTOTAL - 1);
  assign hcnt_d = h_end ? '0 : hcnt_q + HL'(1);
  assign vcnt_d = !h_end ? vcnt_q : v_end ? '0 : vcnt_q + VL'(1);
  // first blanking line, so positions never change inside the visible region
  assign upd    = hcnt_q == '0 && vcnt_q == VL'(VWIDTH) && !pause;
  assign de_d   = hcnt_q < HL'(HWIDTH) && vcnt_q < VL'(VWIDTH);
  assign hs_d   = (hcnt_q >= HL'(HWIDTH + HFPORCH) && hcnt_q < HL'(HWIDTH + HFPORCH + HSYNC)) ? HSA : ~HSA;
  assign vs_d   = (vcnt_q >= VL'(VWIDTH + VFPORCH) && vcnt_q < VL'(VWIDTH + VFPORCH + VSYNC)) ? VSA : ~VSA;
  assign fs_d   = hcnt_q == '0 && vcnt_q == '0;
  for (genvar g = 0; g < NOBJ; g++) begin : g_obj
    logic [PW-1:0] x_q, y_q;
    logic dirx_q, diry_q;
    logic [PW:0] xn, yn;
    logic signed [HL:0] dx;
    logic signed [VL:0] dy;
    logic signed [SW-1:0] d2;
    assign xn = mv(x_q, dirx_q, PW'(HWIDTH - 1 - RADIUS));
    assign yn = mv(y_q, diry_q, PW'(VWIDTH - 1 - RADIUS));
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        x_q    <= PW'(RADIUS + g * ((HWIDTH - 2 * RADIUS) / NOBJ));
        y_q    <= PW'(RADIUS + g * ((VWIDTH - 2 * RADIUS) / NOBJ));
        dirx_q <= 1'(g % 2);
        diry_q <= 1'((g / 2) % 2);
      end else if (upd) begin
        {dirx_q, x_q} <= xn;
        {diry_q, y_q} <= yn;
      end
    assign dx     = $signed({1'b0, hcnt_q}) - $signed({1'b0, x_q[HL-1:0]});
    assign dy     = $signed({1'b0, vcnt_q}) - $signed({1'b0, y_q[VL-1:0]});
    assign d2     = SW'(dx) * SW'(dx) + SW'(dy) * SW'(dy);
    assign hit[g] = d2 <= SW'(RADIUS * RADIUS);
  end
  // descending scan so the lowest-index circle wins overlaps
  always_comb begin
    rgb_d = '0;
    for (int i = NOBJ - 1; i >= 0; i--)
      if (hit[i]) rgb_d = PAL[3*i +: 3];
`ifdef VGA_BORDER_EN
    if (hcnt_q == '0 || hcnt_q == HL'(HWIDTH - 1) || vcnt_q == '0 || vcnt_q == VL'(VWIDTH - 1)) rgb_d = '1;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= ~HSA;
      vs_q   <= ~VSA;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      r_q    <= de_d && rgb_d[2] ? FULL : '0;
      g_q    <= de_d && rgb_d[1] ? FULL : '0;
      b_q    <= de_d && rgb_d[0] ? FULL : '0;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
    end
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_DE      = de_q;
  assign frame_start = fs_q;
endmodule
